// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word-addressed RAM plus a 16-word MMIO window that
// holds a transmit FIFO (valid/ready drain) and a down-counting timer with IRQ.
module dmem_mmio_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0001_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        irq_timer
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [3:0] OFF_TX_DATA     = 4'd0;
  localparam logic [3:0] OFF_STATUS      = 4'd1;
  localparam logic [3:0] OFF_TIMER_LOAD  = 4'd2;
  localparam logic [3:0] OFF_TIMER_VALUE = 4'd3;

  logic [31:0]           r_ram [2**ADDR_WIDTH];
  logic [31:0]           r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic [31:0]           r_timer;
  logic [31:0]           r_timerLoad;
  logic                  r_expired;
  logic [31:0]           r_q;

  logic                  w_mmioHit;
  logic [3:0]            w_offset;
  logic [ADDR_WIDTH-1:0] w_ramIdx;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_pushOk;
  logic                  w_statusWr;
  logic                  w_loadWr;
  logic [31:0]           w_status;
  logic [31:0]           w_mmioRd;

  assign w_mmioHit  = (address_dmem[31:4] == MMIO_BASE[31:4]);
  assign w_offset   = address_dmem[3:0];
  assign w_ramIdx   = address_dmem[ADDR_WIDTH-1:0];

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_push     = wren && w_mmioHit && (w_offset == OFF_TX_DATA);
  assign w_statusWr = wren && w_mmioHit && (w_offset == OFF_STATUS);
  assign w_loadWr   = wren && w_mmioHit && (w_offset == OFF_TIMER_LOAD);
  assign w_pop      = out_valid && out_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign w_pushOk   = w_push && (!w_full || w_pop);

  assign out_valid  = !w_empty;
  assign out_data   = w_empty ? 32'h0 : r_fifo[r_rdPtr];
  assign irq_timer  = r_expired;
  assign q_dmem     = r_q;

  assign w_status   = {20'b0, r_expired, r_overflow, w_empty, w_full, 8'(r_count)};

  always_comb begin
    w_mmioRd = 32'h0;
    case (w_offset)
      OFF_STATUS:      w_mmioRd = w_status;
      OFF_TIMER_LOAD:  w_mmioRd = r_timerLoad;
      OFF_TIMER_VALUE: w_mmioRd = r_timer;
      default:         w_mmioRd = 32'h0;
    endcase
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clock) begin
    if (wren && !w_mmioHit) r_ram[w_ramIdx] <= data;
  end

  always_ff @(posedge clock) begin
    if (reset) r_q <= 32'h0;
    else       r_q <= w_mmioHit ? w_mmioRd : r_ram[w_ramIdx];
  end

  always_ff @(posedge clock) begin
    if (w_pushOk) r_fifo[r_wrPtr] <= data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)    r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A STATUS write beats a simultaneous dropped push.
      if (w_statusWr)                r_overflow <= 1'b0;
      else if (w_push && !w_pushOk)  r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer     <= 32'h0;
      r_timerLoad <= 32'h0;
      r_expired   <= 1'b0;
    end else if (w_loadWr) begin
      r_timer     <= data;
      r_timerLoad <= data;
      r_expired   <= 1'b0;
    end else if (r_timer != 32'h0) begin
      r_timer <= r_timer - 32'h1;
      if (r_timer == 32'h1) r_expired <= 1'b1;
    end
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder on the processor's data-memory interface. Services loads and stores from the M stage.
- Word-addressed synchronous RAM backs ordinary addresses. A small memory-mapped I/O window holds:
  - a transmit FIFO, drained through a valid/ready stream port;
  - a down-counting timer with a sticky expiry flag and an interrupt line.
- Sits in Wrapper beside the processor, replacing the bare dmem.

Parameters:
- ADDR_WIDTH, 12, RAM holds 2^ADDR_WIDTH 32-bit words.
- FIFO_DEPTH, 8, TX FIFO entries. Power of two, 2..128.
- MMIO_BASE, 32'h0001_0000, base of the 16-word I/O window. Bits [3:0] must be zero.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  synchronous, active-high.
- address_dmem  in  32  word address from the processor.
- data  in  32  store data.
- wren  in  1  store enable.
- q_dmem  out  32  load data.
- out_valid  out  1  TX FIFO head valid.
- out_data  out  32  TX FIFO head word.
- out_ready  in  1  downstream accepts head.
- irq_timer  out  1  equals the timer_expired flag.

Behaviour:
- Reset (synchronous, active-high): on the reset edge, FIFO empty, timer=0, overflow=0, timer_expired=0, q_dmem=0. Resulting outputs: out_valid=0, out_data=0, irq_timer=0. RAM contents are not cleared. Reset mid-transfer discards all FIFO contents.
- Decode: mmio_hit = (address_dmem[31:4] == MMIO_BASE[31:4]).
  - Otherwise the access is RAM, indexed by address_dmem[ADDR_WIDTH-1:0]. Upper bits are ignored, so addresses alias.
- RAM read: q_dmem is registered, valid the cycle after the address is presented (1-cycle latency).
- RAM write: when wren=1, the write happens on the edge. A read of the same address in that cycle returns the old data.
- MMIO offsets (address_dmem[3:0]):
  - 0 TX_DATA. A write pushes data. A read returns 0.
  - 1 STATUS. A read returns {20'b0, timer_expired[11], overflow[10], empty[9], full[8], count[7:0]}. Any write clears overflow.
  - 2 TIMER_LOAD. A write loads the timer with data and clears timer_expired. A read returns the last loaded value.
  - 3 TIMER_VALUE. A read returns the current count. Writes are ignored.
  - 4..15: reads return 0, writes ignored.
- MMIO reads use the same 1-cycle registered latency. Values are sampled at the edge, i.e. pre-update state.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit read and write pointers (wrap modulo depth) and a count of 0..FIFO_DEPTH.
  - pop = out_valid & out_ready. out_valid = (count != 0). out_data = mem[rd_ptr], combinational from storage.
  - push is accepted when count < FIFO_DEPTH, or when count == FIFO_DEPTH and pop occurs the same cycle (count stays at depth).
  - A push to a full FIFO without a pop is dropped and sets sticky overflow.
  - Empty FIFO: there is no write-through. A word pushed at edge N appears on out_valid after edge N.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Timer: 32-bit down counter, updated each edge in this priority order:
  1. TIMER_LOAD write: count <= data; timer_expired <= 0.
  2. Else if count != 0: count <= count-1. On the 1->0 transition, timer_expired <= 1 (sticky).
  3. Else hold.
  - Loading 0 never sets expiry.
  - A write to STATUS does not clear timer_expired.
- A TIMER_LOAD write on the same edge as a 1->0 transition: the load wins and expiry is not set.
- An overflow-setting push and a STATUS write on the same edge: the clear wins, so overflow=0.

Test Plan:
- RAM: write 0xDEADBEEF to addr 5, then read addr 5 -> q_dmem=0xDEADBEEF one cycle later. Read addr 5+2^12 -> same value (alias).
- FIFO fill/drain: out_ready=0, push 0..7 to MMIO_BASE+0 -> STATUS=0x108 (full, count 8). 9th push -> STATUS=0x508. Raise out_ready -> out_data 0,1,..,7 on consecutive cycles, then out_valid=0 and STATUS=0x600.
- Full with simultaneous pop: FIFO full, out_ready=1, push 0xAA -> accepted, count stays 8, overflow stays 0, 0xAA emerges 8th.
- Timer: load 3 -> TIMER_VALUE reads 2,1,0 on following cycles. irq_timer rises on the 1->0 edge and stays high. Load 10 -> irq_timer drops next cycle.
- Reset mid-operation: 4 words queued and timer=100, assert reset one cycle -> out_valid=0, STATUS=0x200, TIMER_VALUE=0, irq_timer=0. RAM addr 5 still reads 0xDEADBEEF.
- Unmapped MMIO: write to MMIO_BASE+7, then read MMIO_BASE+7 -> 0. RAM and FIFO are unchanged.
